// File: rtl/regfile_param.sv
// Two-read / one-write register file with a sequenced clear engine.
// Optional hardwired zero register and write-to-read bypass.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  input  logic [ADDR_W-1:0] r_reg1,
  input  logic [ADDR_W-1:0] r_reg2,
  output logic [DATA_W-1:0] r1_data,
  output logic [DATA_W-1:0] r2_data,
  input  logic              r_wr_en,
  input  logic [ADDR_W-1:0] w_reg,
  input  logic [DATA_W-1:0] w_data,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic wr_zero;
  logic wr_ok;

  assign wr_zero = ZERO_REG &&
                   (w_reg == '0);
  assign wr_ok   = r_wr_en &&
                   (state == READY) &&
                   !clr_req &&
                   !wr_zero;
  assign busy    = (state == CLEAR);

  // Clear sequencing, write port and drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      ptr     <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= r_wr_en &&
                 ((state == CLEAR) ||
                  clr_req);
      unique case (state)
        CLEAR: begin
          mem[ptr] <= '0;
          ptr      <= ptr + ADDR_W'(1);
          if (ptr == LAST) begin
            state <= READY;
          end
        end
        READY: begin
          if (clr_req) begin
            state <= CLEAR;
            ptr   <= '0;
          end else if (wr_ok) begin
            mem[w_reg] <= w_data;
          end
        end
      endcase
    end
  end

  // Read port 1 with clear masking, zero reg and bypass.
  always_comb begin
    r1_data = mem[r_reg1];
    if (busy) begin
      r1_data = '0;
    end else if (ZERO_REG &&
                 (r_reg1 == '0)) begin
      r1_data = '0;
    end else if (BYPASS && wr_ok &&
                 (r_reg1 == w_reg)) begin
      r1_data = w_data;
    end
  end

  // Read port 2, independent of port 1.
  always_comb begin
    r2_data = mem[r_reg2];
    if (busy) begin
      r2_data = '0;
    end else if (ZERO_REG &&
                 (r_reg2 == '0)) begin
      r2_data = '0;
    end else if (BYPASS && wr_ok &&
                 (r_reg2 == w_reg)) begin
      r2_data = w_data;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed table, corner
// sequences and random traffic against a model.
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr_req, we;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] wd;

  logic [31:0] a_r1, a_r2, b_r1, b_r2;
  logic [15:0] c_r1, c_r2;
  logic        a_busy, a_drop;
  logic        b_busy, b_drop;
  logic        c_busy, c_drop;

  regfile_param u_a (
    .clk(clk), .rst(rst), .clr_req(clr_req),
    .r_reg1(ra1), .r_reg2(ra2),
    .r1_data(a_r1), .r2_data(a_r2),
    .r_wr_en(we), .w_reg(wa), .w_data(wd),
    .busy(a_busy), .wr_drop(a_drop)
  );

  regfile_param #(.BYPASS(1'b0)) u_b (
    .clk(clk), .rst(rst), .clr_req(clr_req),
    .r_reg1(ra1), .r_reg2(ra2),
    .r1_data(b_r1), .r2_data(b_r2),
    .r_wr_en(we), .w_reg(wa), .w_data(wd),
    .busy(b_busy), .wr_drop(b_drop)
  );

  regfile_param #(
    .DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)
  ) u_c (
    .clk(clk), .rst(rst), .clr_req(clr_req),
    .r_reg1(ra1[2:0]), .r_reg2(ra2[2:0]),
    .r1_data(c_r1), .r2_data(c_r2),
    .r_wr_en(we), .w_reg(wa[2:0]),
    .w_data(wd[15:0]),
    .busy(c_busy), .wr_drop(c_drop)
  );

  // Model: index 0 = 32x32 zero-reg, 1 = 8x16 no zero-reg.
  int          clr_left [2];
  logic [31:0] mm [2][32];
  logic        exp_drop [2];
  int          depth [2] = '{32, 8};
  bit          zr [2] = '{1'b1, 1'b0};

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] ea1;
    logic [31:0] ea2;
    logic [31:0] eb1;
    logic [31:0] eb2;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [4:0] am(
    int m, logic [4:0] a);
    return (m == 1) ? (a & 5'd7) : a;
  endfunction

  function automatic logic [31:0] dm(
    int m, logic [31:0] d);
    return (m == 1) ? (d & 32'hFFFF) : d;
  endfunction

  function automatic bit acc(int m);
    return we && (clr_left[m] == 0) &&
           !clr_req &&
           !(zr[m] && (am(m, wa) == 5'd0));
  endfunction

  function automatic logic [31:0] exp_rd(
    int m, bit byp, logic [4:0] a);
    logic [4:0] x;
    x = am(m, a);
    if (clr_left[m] > 0) return 32'd0;
    if (zr[m] && (x == 5'd0)) return 32'd0;
    if (byp && acc(m) && (x == am(m, wa)))
      return dm(m, wd);
    return mm[m][x];
  endfunction

  task automatic chk(
    string name, logic [31:0] act,
    logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic model_edge(int m);
    if (rst) begin
      clr_left[m] = depth[m];
      exp_drop[m] = 1'b0;
    end else if (clr_left[m] > 0) begin
      exp_drop[m] = we;
      clr_left[m]--;
      if (clr_left[m] == 0)
        for (int i = 0; i < 32; i++)
          mm[m][i] = 32'd0;
    end else begin
      exp_drop[m] = we && clr_req;
      if (clr_req)
        clr_left[m] = depth[m];
      else if (acc(m))
        mm[m][am(m, wa)] = dm(m, wd);
    end
  endtask

  task automatic cycle(bit do_chk);
    @(negedge clk);
    if (do_chk) begin
      chk("a_r1", a_r1, exp_rd(0, 1'b1, ra1));
      chk("a_r2", a_r2, exp_rd(0, 1'b1, ra2));
      chk("b_r1", b_r1, exp_rd(0, 1'b0, ra1));
      chk("b_r2", b_r2, exp_rd(0, 1'b0, ra2));
      chk("c_r1", {16'h0, c_r1},
          exp_rd(1, 1'b1, ra1));
      chk("c_r2", {16'h0, c_r2},
          exp_rd(1, 1'b1, ra2));
      chk("a_busy", a_busy, clr_left[0] > 0);
      chk("b_busy", b_busy, clr_left[0] > 0);
      chk("c_busy", c_busy, clr_left[1] > 0);
      chk("a_drop", a_drop, exp_drop[0]);
      chk("b_drop", b_drop, exp_drop[0]);
      chk("c_drop", c_drop, exp_drop[1]);
    end
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic wait_ready(
    output int na, output int nc,
    output int nd);
    na = 0;
    nc = 0;
    nd = 0;
    while (a_busy && na < 40) begin
      na++;
      if (c_busy) nc++;
      if (a_drop) nd++;
      cycle(1'b1);
    end
  endtask

  int na, nc, nd;

  initial begin
    for (int m = 0; m < 2; m++) begin
      clr_left[m] = depth[m];
      exp_drop[m] = 1'b0;
    end
    tbl[0] = '{1, 5, 32'hDEADBEEF, 5, 5,
               32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
    tbl[1] = '{0, 0, 0, 5, 5,
               32'hDEADBEEF, 32'hDEADBEEF,
               32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{1, 0, 32'h1, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{1, 9, 32'h12345678, 5, 9,
               32'hDEADBEEF, 32'h12345678,
               32'hDEADBEEF, 0};
    tbl[4] = '{0, 0, 0, 9, 0,
               32'h12345678, 0,
               32'h12345678, 0};
    tbl[5] = '{1, 9, 32'hCAFEF00D, 9, 9,
               32'hCAFEF00D, 32'hCAFEF00D,
               32'h12345678, 32'h12345678};
    tbl[6] = '{0, 0, 0, 9, 5,
               32'hCAFEF00D, 32'hDEADBEEF,
               32'hCAFEF00D, 32'hDEADBEEF};

    rst = 1'b1;
    clr_req = 1'b0;
    we = 1'b0;
    ra1 = 5'd7;
    ra2 = 5'd0;
    wa = 5'd0;
    wd = 32'd0;

    // reset then initial clear
    cycle(1'b0);
    cycle(1'b1);
    rst = 1'b0;
    wait_ready(na, nc, nd);
    chk("clear_len_a", na, 32);
    chk("clear_len_c", nc, 8);
    chk("clear_drops", nd, 0);
    chk("post_clear_r1", a_r1, 0);

    // write during clear cycle 10 is dropped
    rst = 1'b1;
    cycle(1'b1);
    rst = 1'b0;
    ra1 = 5'd3;
    for (int i = 0; i < 9; i++) cycle(1'b1);
    we = 1'b1;
    wa = 5'd3;
    wd = 32'hAA;
    cycle(1'b1);
    we = 1'b0;
    chk("drop_pulse", a_drop, 1);
    wait_ready(na, nc, nd);
    chk("drop_clear_len", na, 22);
    chk("drop_reg3", a_r1, 0);

    // directed table
    for (int i = 0; i < 7; i++) begin
      we = tbl[i].we;
      wa = tbl[i].wa;
      wd = tbl[i].wd;
      ra1 = tbl[i].ra1;
      ra2 = tbl[i].ra2;
      #1;
      chk($sformatf("tbl%0d_a1", i), a_r1, tbl[i].ea1);
      chk($sformatf("tbl%0d_a2", i), a_r2, tbl[i].ea2);
      chk($sformatf("tbl%0d_b1", i), b_r1, tbl[i].eb1);
      chk($sformatf("tbl%0d_b2", i), b_r2, tbl[i].eb2);
      chk($sformatf("tbl%0d_dr", i), a_drop, 0);
      cycle(1'b1);
    end

    // fill 1..31 then clr_req with a colliding write
    for (int i = 1; i < 32; i++) begin
      we = 1'b1;
      wa = 5'(i);
      wd = 32'(i);
      cycle(1'b1);
    end
    we = 1'b0;
    ra1 = 5'd17;
    #1;
    chk("fill_r17", a_r1, 17);
    clr_req = 1'b1;
    we = 1'b1;
    wa = 5'd4;
    wd = 32'h44;
    cycle(1'b1);
    clr_req = 1'b0;
    we = 1'b0;
    chk("clr_busy", a_busy, 1);
    chk("clr_drop", a_drop, 1);
    wait_ready(na, nc, nd);
    chk("clr_len", na, 32);
    chk("clr_drops", nd, 1);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      chk($sformatf("zero_r1_%0d", i), a_r1, 0);
      chk($sformatf("zero_r2_%0d", i), b_r2, 0);
      cycle(1'b1);
    end

    // narrow instance: register 0 is writable
    we = 1'b1;
    wa = 5'd0;
    wd = 32'h0000BEEF;
    cycle(1'b1);
    we = 1'b0;
    ra1 = 5'd0;
    #1;
    chk("c_reg0", {16'h0, c_r1}, 32'hBEEF);
    chk("a_reg0", a_r1, 0);
    cycle(1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      clr_req = ($urandom_range(0, 59) == 0);
      we = ($urandom_range(0, 2) != 0);
      wa = 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ?
            wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ?
            wa : 5'($urandom_range(0, 31));
      wd = $urandom;
      cycle(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised two-read / one-write general-purpose register file for the MIPS datapath. It sits between decode, which supplies the read addresses, and writeback, which supplies the write port. Compared with the earlier fixed 32x32 array, it adds:
- a working synchronous write port;
- configurable width and depth;
- an optional hardwired-zero register 0;
- optional write-to-read bypass;
- a sequenced clear engine that zeroes the array after reset or on request.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes
- BYPASS, 1, when 1 a same-cycle accepted write is forwarded to matching read ports

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- clr_req  in  1  request a full clear sequence; sampled when READY
- r_reg1  in  ADDR_W  read port 1 address
- r_reg2  in  ADDR_W  read port 2 address
- r1_data  out  DATA_W  read port 1 data, combinational
- r2_data  out  DATA_W  read port 2 data, combinational
- r_wr_en  in  1  write enable
- w_reg  in  ADDR_W  write address
- w_data  in  DATA_W  write data
- busy  out  1  high while the clear engine runs
- wr_drop  out  1  registered one-cycle pulse: a write with r_wr_en=1 was rejected

## Operation
The state machine has two states, CLEAR and READY. It holds a clear pointer ptr of ADDR_W bits.

State behaviour:
- rst=1 at an edge: state<=CLEAR, ptr<=0, wr_drop<=0. The array contents are not touched on that edge.
- CLEAR, each edge with rst=0: mem[ptr]<=0, ptr<=ptr+1. When ptr==DEPTH-1: state<=READY, and ptr wraps to 0.
- READY with clr_req=1: state<=CLEAR, ptr<=0 on the next edge.

Write acceptance:
- A write is accepted when r_wr_en=1, state==READY, clr_req=0, and not (ZERO_REG=1 and w_reg==0). An accepted write does mem[w_reg]<=w_data.
- wr_drop<=1 when r_wr_en=1 and the write is rejected because state==CLEAR or clr_req=1. Otherwise wr_drop<=0.
- A write to register 0 with ZERO_REG=1 is silently ignored. It does not set wr_drop.

Reads, evaluated per port in priority order:
1. state==CLEAR → 0.
2. ZERO_REG=1 and address==0 → 0.
3. BYPASS=1, write accepted this cycle, and address==w_reg → w_data.
4. Otherwise → mem[address].

Other rules:
- Both read ports are fully independent. Identical addresses on the two ports are legal.
- No arithmetic on data. ptr increments modulo DEPTH.

## Timing
Reset and clear sequencing:
- Reset values: busy=1 (state CLEAR), wr_drop=0, ptr=0. r1_data and r2_data read 0 while busy.
- Clear latency: DEPTH edges after the last rst=1 edge. busy falls after the DEPTH-th edge with rst=0, which is 32 cycles by default.
- rst asserted mid-clear restarts the sequence at ptr=0.
- clr_req mid-clear is ignored, because the clear is already in progress.
- busy is the registered state (state==CLEAR). It is not combinational from clr_req.

Writes and reads:
- Write-to-read latency is 0 cycles with BYPASS=1. With BYPASS=0 it is 1 cycle: the value is visible after the write edge.
- A write and a read of the same address in one cycle return old data when BYPASS=0.
- A write on the same edge as a clr_req=1 sample is dropped, and wr_drop pulses on the following cycle.
- The first write accepted after a clear is the one in the first cycle with busy=0.

## Test plan
1. Reset/clear: rst=1 for 2 cycles, then release; hold r_reg1=7 → busy=1 for exactly 32 cycles; r1_data=0 throughout and after; wr_drop=0.
2. Write/read: after busy=0, write w_reg=5, w_data=0xDEADBEEF; next cycle r_reg1=5, r_reg2=5 → both ports read 0xDEADBEEF. Write 0x1 to w_reg=0 → r1_data at address 0 stays 0, and wr_drop=0.
3. Bypass: BYPASS=1, write w_reg=9, w_data=0x12345678 with r_reg2=9 in the same cycle → r2_data=0x12345678 in that cycle. Repeat with BYPASS=0 → r2_data shows the old value, then 0x12345678 the next cycle.
4. Dropped write: r_wr_en=1, w_reg=3, w_data=0xAA during clear cycle 10 → wr_drop=1 on the next cycle; after the clear, register 3 reads 0.
5. clr_req: fill registers 1..31 with their index, then pulse clr_req with a simultaneous write to register 4 → busy=1 for 32 cycles; wr_drop pulses once; afterwards all registers read 0.
6. Parameter sweep: DATA_W=16, ADDR_W=3, ZERO_REG=0 → busy lasts 8 cycles; register 0 accepts a write of 0xBEEF and reads it back.
